// File: rtl/pifo_pop_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pifo_pop_ctrl                                              |
// | Description : Pop-side PIFO client. Round-robin picks the next output    |
// |               port, issues pop_0/oprt_0 and matches each PIFO response   |
// |               (POP_LAT cycles later) to its port for the egress stream.  |
// |               Per-port credits plus one-outstanding-pop-per-port keep    |
// |               the PIFO and the egress queues from being over-popped.     |
// | Option      : PIFO_POP_STATS_EN adds the stat_pops/stat_deqs/stat_empty  |
// |               32-bit wrapping event counters.                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pifo_pop_ctrl #(
  parameter int NUMPORT = 4,
  parameter int BITPORT = 8,
  parameter int BITPRIO = 16,
  parameter int BITDATA = 32,
  parameter int POP_LAT = 2,
  parameter int CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst,            // asynchronous, active-low
  input  logic               enable,
  input  logic [NUMPORT-1:0] port_nonempty,
  input  logic [NUMPORT-1:0] cred_ret,
  output logic               pop_0,
  output logic [BITPORT-1:0] oprt_0,
  input  logic               ovld_0,
  input  logic [BITPRIO-1:0] opri_0,
  input  logic [BITDATA-1:0] odout_0,
  output logic               deq_vld,
  output logic [BITPORT-1:0] deq_port,
  output logic [BITPRIO-1:0] deq_prio,
  output logic [BITDATA-1:0] deq_data,
  output logic               cred_err
`ifdef PIFO_POP_STATS_EN
  ,
  output logic [31:0]        stat_pops,
  output logic [31:0]        stat_deqs,
  output logic [31:0]        stat_empty
`endif
);

  localparam int              PW        = (NUMPORT > 1) ? $clog2(NUMPORT) : 1;
  localparam int              CW        = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]   CRED_MAX  = CW'(CREDITS);
  localparam logic [PW-1:0]   LAST_PORT = PW'(NUMPORT - 1);

  logic [CW-1:0]      credit_q [NUMPORT];
  logic [CW-1:0]      credit_d [NUMPORT];
  logic [NUMPORT-1:0] err_set;
  logic [NUMPORT-1:0] inflight_q, inflight_d;
  logic [NUMPORT-1:0] elig;
  logic [PW-1:0]      rr_ptr_q;
  logic               grant_vld;
  logic [PW-1:0]      grant_port;
  logic [PW-1:0]      pop_port_q;
  logic [POP_LAT-1:0] tag_vld_q;
  logic [PW-1:0]      tag_port_q [POP_LAT];
  logic               resp_vld;
  logic [PW-1:0]      resp_port;
  logic               resp_empty;

  // Response tag and eligibility; a port whose response lands this cycle is
  // treated as no longer in flight so it can be re-granted immediately.
  always_comb begin
    resp_vld   = tag_vld_q[POP_LAT-1];
    resp_port  = tag_port_q[POP_LAT-1];
    resp_empty = resp_vld & ~ovld_0;
    for (int p = 0; p < NUMPORT; p++) begin
      elig[p] = enable & port_nonempty[p] & (credit_q[p] != '0) &
                ~(inflight_q[p] & ~(resp_vld && (resp_port == PW'(p))));
    end
  end

  // Round-robin scan of eligible ports starting at the pointer.
  always_comb begin
    logic [PW-1:0] scan;
    grant_vld  = 1'b0;
    grant_port = '0;
    scan       = rr_ptr_q;
    for (int i = 0; i < NUMPORT; i++) begin
      if (!grant_vld && elig[scan]) begin
        grant_vld  = 1'b1;
        grant_port = scan;
      end
      scan = (scan == LAST_PORT) ? '0 : scan + 1'b1;
    end
  end

  // In-flight bookkeeping: the response clears first so a same-cycle grant wins.
  always_comb begin
    inflight_d = inflight_q;
    if (resp_vld)  inflight_d[resp_port]  = 1'b0;
    if (grant_vld) inflight_d[grant_port] = 1'b1;
  end

  // Credit next-state: grant -1, egress return +1, empty-response restore +1,
  // saturating at CREDITS with an overflow flag.
  always_comb begin
    logic [CW+1:0] sum;
    sum     = '0;
    err_set = '0;
    for (int p = 0; p < NUMPORT; p++) begin
      sum = {2'b00, credit_q[p]}
          + (CW+2)'(cred_ret[p])
          + (CW+2)'(resp_empty && (resp_port == PW'(p)))
          - (CW+2)'(grant_vld && (grant_port == PW'(p)));
      if (sum > {2'b00, CRED_MAX}) begin
        credit_d[p] = CRED_MAX;
        err_set[p]  = 1'b1;
      end else begin
        credit_d[p] = sum[CW-1:0];
      end
    end
  end

  // Registered pop issue, tag pipeline, credits and the dequeue stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_0      <= 1'b0;
      oprt_0     <= '0;
      pop_port_q <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      tag_vld_q  <= '0;
      cred_err   <= 1'b0;
      deq_vld    <= 1'b0;
      deq_port   <= '0;
      deq_prio   <= '0;
      deq_data   <= '0;
      for (int k = 0; k < POP_LAT; k++) tag_port_q[k] <= '0;
      for (int p = 0; p < NUMPORT; p++) credit_q[p] <= CRED_MAX;
    end else begin
      pop_0 <= grant_vld;
      if (grant_vld) begin
        oprt_0     <= BITPORT'(grant_port);
        pop_port_q <= grant_port;
        rr_ptr_q   <= (grant_port == LAST_PORT) ? '0 : grant_port + 1'b1;
      end
      tag_vld_q[0]  <= pop_0;
      tag_port_q[0] <= pop_port_q;
      for (int k = 1; k < POP_LAT; k++) begin
        tag_vld_q[k]  <= tag_vld_q[k-1];
        tag_port_q[k] <= tag_port_q[k-1];
      end
      inflight_q <= inflight_d;
      for (int p = 0; p < NUMPORT; p++) credit_q[p] <= credit_d[p];
      cred_err <= cred_err | (|err_set);
      deq_vld  <= resp_vld & ovld_0;
      if (resp_vld & ovld_0) begin
        deq_port <= BITPORT'(resp_port);
        deq_prio <= opri_0;
        deq_data <= odout_0;
      end
    end
  end

`ifdef PIFO_POP_STATS_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_pops  <= '0;
      stat_deqs  <= '0;
      stat_empty <= '0;
    end else begin
      if (grant_vld)         stat_pops  <= stat_pops + 32'd1;
      if (resp_vld & ovld_0) stat_deqs  <= stat_deqs + 32'd1;
      if (resp_empty)        stat_empty <= stat_empty + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pifo_pop_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pifo_pop_ctrl                                           |
// | Description : Directed self-checking bench for pifo_pop_ctrl with a      |
// |               fixed-latency PIFO responder (POP_LAT = 2).                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pifo_pop_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  port_nonempty = '0;
  logic [3:0]  cred_ret = '0;
  logic        pop_0;
  logic [7:0]  oprt_0;
  logic        ovld_0 = 1'b0;
  logic [15:0] opri_0 = '0;
  logic [31:0] odout_0 = '0;
  logic        deq_vld;
  logic [7:0]  deq_port;
  logic [15:0] deq_prio;
  logic [31:0] deq_data;
  logic        cred_err;
`ifdef PIFO_POP_STATS_EN
  logic [31:0] stat_pops, stat_deqs, stat_empty;
`endif

  always #5 clk = ~clk;

  pifo_pop_ctrl #(
    .NUMPORT(4), .BITPORT(8), .BITPRIO(16), .BITDATA(32), .POP_LAT(2), .CREDITS(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .port_nonempty(port_nonempty),
    .cred_ret(cred_ret), .pop_0(pop_0), .oprt_0(oprt_0), .ovld_0(ovld_0),
    .opri_0(opri_0), .odout_0(odout_0), .deq_vld(deq_vld), .deq_port(deq_port),
    .deq_prio(deq_prio), .deq_data(deq_data), .cred_err(cred_err)
`ifdef PIFO_POP_STATS_EN
    , .stat_pops(stat_pops), .stat_deqs(stat_deqs), .stat_empty(stat_empty)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Responder history: pop seen in cycle t, t-1, t-2.
  logic        h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  logic [7:0]  h0p = '0, h1p = '0, h2p = '0;
  logic        resp_mode  = 1'b1;
  logic        force_ovld = 1'b0;
  logic        exp_dv = 1'b0;
  logic [7:0]  exp_port = '0;
  logic [15:0] exp_prio = '0;
  logic [31:0] exp_data = '0;
  int          pop_q[$];
  int          popcyc_q[$];

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clear_hist();
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    exp_dv = 1'b0;
    ovld_0 = 1'b0;
  endtask

  // Advance one cycle, check the dequeue expected from last cycle, then play
  // the PIFO: answer the pop issued two cycles ago.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk_eq("deq_vld", 64'(deq_vld), 64'(exp_dv));
    if (exp_dv) begin
      chk_eq("deq_port", 64'(deq_port), 64'(exp_port));
      chk_eq("deq_prio", 64'(deq_prio), 64'(exp_prio));
      chk_eq("deq_data", 64'(deq_data), 64'(exp_data));
    end
    h2 = h1; h2p = h1p;
    h1 = h0; h1p = h0p;
    h0 = pop_0 & rst; h0p = oprt_0;
    if (h0) begin
      pop_q.push_back(int'(oprt_0));
      popcyc_q.push_back(cyc);
    end
    ovld_0  = force_ovld | (h2 & resp_mode);
    opri_0  = {8'hA5, h2p};
    odout_0 = 32'hD000_0000 | 32'(cyc);
    exp_dv   = ovld_0 & h2 & rst;
    exp_port = h2p;
    exp_prio = opri_0;
    exp_data = odout_0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_hist();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk_eq("rst_pop_0", 64'(pop_0), 64'd0);
    chk_eq("rst_oprt_0", 64'(oprt_0), 64'd0);
    chk_eq("rst_deq_port", 64'(deq_port), 64'd0);
    chk_eq("rst_cred_err", 64'(cred_err), 64'd0);
    for (int p = 0; p < 4; p++) chk_eq("rst_credit", 64'(dut.credit_q[p]), 64'd4);

    // ---------------- ports 0 and 2 alternate until credits run out ----------------
    enable = 1'b1;
    port_nonempty = 4'b0101;
    pop_q.delete(); popcyc_q.delete();
    for (int i = 0; i < 20; i++) step();
    chk_eq("t1_npops", 64'(pop_q.size()), 64'd8);
    for (int i = 0; i < pop_q.size(); i++)
      chk_eq("t1_port", 64'(pop_q[i]), (i % 2 == 0) ? 64'd0 : 64'd2);
    chk_eq("t1_credit0", 64'(dut.credit_q[0]), 64'd0);
    chk_eq("t1_credit2", 64'(dut.credit_q[2]), 64'd0);

    // ---------------- credit return re-enables port 0 ----------------
    cred_ret = 4'b0001;
    step();
    cred_ret = 4'b0000;
    chk_eq("t4_pop_early", 64'(pop_0), 64'd0);
    step();
    chk_eq("t4_pop_0", 64'(pop_0), 64'd1);
    chk_eq("t4_oprt_0", 64'(oprt_0), 64'd0);
    port_nonempty = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    chk_eq("t4_credit0_used", 64'(dut.credit_q[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cred_ret = 4'b0001;
      step();
    end
    cred_ret = 4'b0000;
    chk_eq("t4_credit0_full", 64'(dut.credit_q[0]), 64'd4);
    chk_eq("t4_no_err", 64'(cred_err), 64'd0);
    cred_ret = 4'b0001;
    step();
    cred_ret = 4'b0000;
    chk_eq("t4_cred_err", 64'(cred_err), 64'd1);
    chk_eq("t4_credit0_sat", 64'(dut.credit_q[0]), 64'd4);
    step();
    chk_eq("t4_err_sticky", 64'(cred_err), 64'd1);

    // ---------------- single port 1: one pop every 3 cycles ----------------
    pop_q.delete(); popcyc_q.delete();
    port_nonempty = 4'b0010;
    for (int i = 0; i < 12; i++) step();
    port_nonempty = 4'b0000;
    for (int i = 0; i < 4; i++) step();
    chk_eq("t2_npops", 64'(pop_q.size()), 64'd4);
    for (int i = 0; i < pop_q.size(); i++) chk_eq("t2_port", 64'(pop_q[i]), 64'd1);
    for (int i = 1; i < popcyc_q.size(); i++)
      chk_eq("t2_gap", 64'(popcyc_q[i] - popcyc_q[i-1]), 64'd3);

    // ---------------- port 3 answered empty: credit restored ----------------
    resp_mode = 1'b0;
    pop_q.delete(); popcyc_q.delete();
    port_nonempty = 4'b1000;
    step();
    chk_eq("t3_pop_0", 64'(pop_0), 64'd1);
    chk_eq("t3_oprt_0", 64'(oprt_0), 64'd3);
    port_nonempty = 4'b0000;
    step();
    chk_eq("t3_credit3_used", 64'(dut.credit_q[3]), 64'd3);
    step();
    step();
    chk_eq("t3_credit3_back", 64'(dut.credit_q[3]), 64'd4);
    chk_eq("t3_npops", 64'(pop_q.size()), 64'd1);
`ifdef PIFO_POP_STATS_EN
    chk_eq("t3_stat_empty", 64'(stat_empty), 64'd1);
`endif
    step();
    resp_mode = 1'b1;

    // ---------------- all ports: strict 0,1,2,3 rotation ----------------
    do_reset();
    pop_q.delete(); popcyc_q.delete();
    port_nonempty = 4'b1111;
    for (int i = 0; i < 20; i++) step();
    port_nonempty = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    chk_eq("t5_npops", 64'(pop_q.size()), 64'd16);
    for (int i = 0; i < pop_q.size(); i++) chk_eq("t5_port", 64'(pop_q[i]), 64'(i % 4));

    // ---------------- reset with two pops in flight ----------------
    do_reset();
    port_nonempty = 4'b0011;
    step();
    step();
    chk_eq("t6_pop_before_rst", 64'(pop_0), 64'd1);
    rst = 1'b0;
    clear_hist();
    #1;
    chk_eq("t6_pop_in_rst", 64'(pop_0), 64'd0);
    chk_eq("t6_deq_in_rst", 64'(deq_vld), 64'd0);
    enable = 1'b0;
    port_nonempty = 4'b0000;
    step();
    chk_eq("t6_pop_in_rst2", 64'(pop_0), 64'd0);
    step();
    rst = 1'b1;
    force_ovld = 1'b1;
    ovld_0 = 1'b1;
    for (int i = 0; i < 4; i++) step();
    force_ovld = 1'b0;
    ovld_0 = 1'b0;
    step();
    chk_eq("t6_deq_after", 64'(deq_vld), 64'd0);
    for (int p = 0; p < 4; p++) chk_eq("t6_credit", 64'(dut.credit_q[p]), 64'd4);
    chk_eq("t6_cred_err", 64'(cred_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
